// File: rtl/nx_mesh_egress.sv
`default_nettype none
// ============================================================================
//  Module   : nx_mesh_egress
//  Purpose  : Merges CHANNELS mesh-column message streams into one outbound
//             stream. A round-robin arbiter selects a column and the chosen
//             message is buffered in a FIFO_DEPTH-entry output FIFO.
//  Options  : NX_EGRESS_COUNT_EN adds sent_count_o, a 32-bit wrapping count
//             of outbound transfers.
//  Revision : 1.0  initial release
// ============================================================================
module nx_mesh_egress #(
    parameter int CHANNELS     = 3,
    parameter int STREAM_WIDTH = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [CHANNELS*STREAM_WIDTH-1:0] ch_data_i,
    input  logic [CHANNELS-1:0]              ch_valid_i,
    output logic [CHANNELS-1:0]              ch_ready_o,
    output logic [STREAM_WIDTH-1:0]          outbound_data_o,
    output logic                             outbound_valid_o,
    input  logic                             outbound_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]      level_o,
    output logic                             idle_o
`ifdef NX_EGRESS_COUNT_EN
    ,
    output logic [31:0]                      sent_count_o
`endif
);

    localparam int c_PTR_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W  = c_ADDR_W + 1;

    localparam logic [c_PTR_W-1:0]  c_LAST_CH  = c_PTR_W'(CHANNELS - 1);
    localparam logic [c_LVL_W-1:0]  c_FULL_LVL = c_LVL_W'(FIFO_DEPTH);
    localparam logic [CHANNELS-1:0] c_ONE_HOT0 = CHANNELS'(1);

    // Arbiter and FIFO state
    logic [c_PTR_W-1:0]      ptr_q, ptr_d;
    logic [c_LVL_W-1:0]      level_q, level_d;
    logic [c_ADDR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [STREAM_WIDTH-1:0] mem_q [FIFO_DEPTH];

    // Combinational control
    logic                    w_gnt_any;
    logic [c_PTR_W-1:0]      w_gnt_idx;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic [STREAM_WIDTH-1:0] w_push_data;

    assign w_full  = (level_q == c_FULL_LVL);
    assign w_empty = (level_q == '0);

    // Round-robin search: first valid channel starting at ptr, wrapping modulo CHANNELS
    always_comb begin
        int idx;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        idx       = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!w_gnt_any && ch_valid_i[idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = c_PTR_W'(idx);
            end
        end
    end

    // A grant is only offered when there is room; a pop in the same cycle does
    // not free space for a push, which keeps outbound_ready_i off this path.
    assign w_push      = w_gnt_any && !w_full && !rst_i;
    assign ch_ready_o  = w_push ? (c_ONE_HOT0 << w_gnt_idx) : '0;
    assign w_push_data = ch_data_i[w_gnt_idx*STREAM_WIDTH +: STREAM_WIDTH];
    assign w_pop       = !w_empty && outbound_ready_i && !rst_i;

    // Next pointer and occupancy
    always_comb begin
        ptr_d   = ptr_q;
        level_d = level_q;
        if (w_push) begin
            ptr_d = (w_gnt_idx == c_LAST_CH) ? '0 : (w_gnt_idx + 1'b1);
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Control registers; reset discards everything buffered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q    <= '0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            level_q <= level_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care while the entry is unoccupied
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_push_data;
        end
    end

    assign outbound_valid_o = !w_empty;
    assign outbound_data_o  = w_empty ? '0 : mem_q[rd_ptr_q];
    assign level_o          = level_q;
    assign idle_o           = w_empty && (ch_valid_i == '0);

`ifdef NX_EGRESS_COUNT_EN
    logic [31:0] sent_count_q;

    // Outbound transfer counter, wraps naturally at 2^32
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sent_count_q <= '0;
        end else if (w_pop) begin
            sent_count_q <= sent_count_q + 32'd1;
        end
    end

    assign sent_count_o = sent_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nx_mesh_egress.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nx_mesh_egress
//  Purpose  : Randomised scoreboard bench for nx_mesh_egress with a
//             queue-based round-robin/FIFO reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nx_mesh_egress;

    localparam int CH    = 3;
    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic [CH*W-1:0]   ch_data_i = '0;
    logic [CH-1:0]     ch_valid_i = '0;
    logic [CH-1:0]     ch_ready_o;
    logic [W-1:0]      outbound_data_o;
    logic              outbound_valid_o;
    logic              outbound_ready_i = 1'b0;
    logic [LW-1:0]     level_o;
    logic              idle_o;
`ifdef NX_EGRESS_COUNT_EN
    logic [31:0]       sent_count_o;
`endif

    nx_mesh_egress #(
        .CHANNELS    (CH),
        .STREAM_WIDTH(W),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .ch_data_i       (ch_data_i),
        .ch_valid_i      (ch_valid_i),
        .ch_ready_o      (ch_ready_o),
        .outbound_data_o (outbound_data_o),
        .outbound_valid_o(outbound_valid_o),
        .outbound_ready_i(outbound_ready_i),
        .level_o         (level_o),
        .idle_o          (idle_o)
`ifdef NX_EGRESS_COUNT_EN
        ,
        .sent_count_o    (sent_count_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int           m_ptr = 0;
    int           m_lvl = 0;
    logic [W-1:0] expq[$];
    logic [W-1:0] out_log[$];
    logic [CH-1:0] last_acc = '0;
    bit           p_rst = 1'b1, p_push = 1'b0, p_pop = 1'b0;
    int           p_gnt = 0;
    logic [W-1:0] p_data = '0;
    logic [CH-1:0] prev_v = '0;
    logic [CH*W-1:0] prev_d = '0;
    logic [CH-1:0] prev_acc = '0;
    bit           prev_rst = 1'b1;

    // Predict the grant from the rules, compare, and stage the state update
    always @(negedge clk) begin
        logic [CH-1:0] e_rdy;
        int e_gnt;
        e_rdy = '0;
        e_gnt = 0;
        for (int c = 0; c < CH; c++) begin
            if (prev_v[c] && !prev_acc[c] && !prev_rst) begin
                chk("hold_valid", ch_valid_i[c], 1'b1);
                chk("hold_data", ch_data_i[c*W +: W], prev_d[c*W +: W]);
            end
        end
        if (!rst_i && m_lvl < DEPTH) begin
            for (int k = 0; k < CH; k++) begin
                int c;
                c = (m_ptr + k) % CH;
                if (ch_valid_i[c] && e_rdy == '0) begin
                    e_rdy[c] = 1'b1;
                    e_gnt = c;
                end
            end
        end
        chk("ch_ready", ch_ready_o, e_rdy);
        chk("level", level_o, m_lvl);
        chk("idle", idle_o, (m_lvl == 0) && (ch_valid_i == '0));
        last_acc = e_rdy & ch_valid_i;
        p_push   = (last_acc != '0);
        p_gnt    = e_gnt;
        p_data   = ch_data_i[e_gnt*W +: W];
        p_pop    = !rst_i && (m_lvl != 0) && outbound_ready_i;
        p_rst    = rst_i;
        prev_v   = ch_valid_i;
        prev_d   = ch_data_i;
        prev_acc = last_acc;
        prev_rst = rst_i;
    end

    // Apply the staged model update at the same edge the DUT updates
    always @(posedge clk) begin
        if (p_rst) begin
            m_lvl = 0;
            m_ptr = 0;
            expq.delete();
        end else begin
            if (p_push) begin
                expq.push_back(p_data);
                m_ptr = (p_gnt + 1) % CH;
            end
            m_lvl = m_lvl + (p_push ? 1 : 0) - (p_pop ? 1 : 0);
        end
    end

    // Output monitor: compares the presented head against the scoreboard
    always @(negedge clk) begin
        if (!rst_i) begin
            chk("out_valid", outbound_valid_o, expq.size() != 0);
            if (expq.size() != 0) begin
                chk("out_data", outbound_data_o, expq[0]);
                if (outbound_valid_o && outbound_ready_i) begin
                    out_log.push_back(outbound_data_o);
                    void'(expq.pop_front());
                end
            end else begin
                chk("out_zero", outbound_data_o, '0);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [CH-1:0] en_mask = '0;
    int p_valid = 0;
    int rdy_pct = 0;
    bit seq_mode = 1'b0;
    int seq_val = 0;
    int seq_lim = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of protocol-respecting random stimulus
    task automatic step();
        tick();
        for (int c = 0; c < CH; c++) begin
            if (ch_valid_i[c] && !last_acc[c]) begin
                continue;
            end
            if (en_mask[c] && ($urandom % 100) < p_valid && !(seq_mode && seq_val >= seq_lim)) begin
                ch_valid_i[c] = 1'b1;
                ch_data_i[c*W +: W] = seq_mode ? W'(seq_val) : $urandom;
                if (seq_mode) seq_val++;
            end else begin
                ch_valid_i[c] = 1'b0;
            end
        end
        outbound_ready_i = ($urandom % 100) < rdy_pct;
    endtask

    task automatic drain();
        en_mask = '0; p_valid = 0; rdy_pct = 100; seq_mode = 1'b0;
        repeat (12) step();
    endtask

    task automatic apply_reset(input int n);
        rst_i = 1'b1;
        tick();
        ch_valid_i = '0;
        outbound_ready_i = 1'b0;
        repeat (n - 1) tick();
        rst_i = 1'b0;
    endtask

    initial begin
        apply_reset(3);
        @(negedge clk);
        chk("rst_level", level_o, 0);
        chk("rst_valid", outbound_valid_o, 1'b0);

        // Single message on channel 1
        repeat (5) tick();
        ch_valid_i = 3'b010;
        ch_data_i[1*W +: W] = 32'hA5A5_0001;
        outbound_ready_i = 1'b1;
        @(negedge clk);
        chk("single_ready", ch_ready_o, 3'b010);
        tick();
        ch_valid_i = '0;
        @(negedge clk);
        chk("single_valid", outbound_valid_o, 1'b1);
        chk("single_data", outbound_data_o, 32'hA5A5_0001);
        tick();
        @(negedge clk);
        chk("single_level0", level_o, 0);

        // Fairness with all channels continuously valid
        apply_reset(2);
        en_mask = 3'b111; p_valid = 100; rdy_pct = 100;
        step();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_order", ch_ready_o, 3'b001 << (k % 3));
            step();
        end
        drain();

        // Wrap-around: 0..19 through the FIFO with random backpressure
        out_log.delete();
        en_mask = 3'b001; p_valid = 100; rdy_pct = 50;
        seq_mode = 1'b1; seq_val = 0; seq_lim = 20;
        repeat (120) step();
        drain();
        chk("wrap_count", out_log.size(), 20);
        for (int i = 0; i < 20; i++) begin
            chk("wrap_value", (i < out_log.size()) ? out_log[i] : 32'hDEAD_BEEF, i);
        end

        // Backpressure: fill, then one pop cycle with a refused push
        en_mask = 3'b001; p_valid = 100; rdy_pct = 0;
        repeat (6) step();
        @(negedge clk);
        chk("bp_full_level", level_o, DEPTH);
        chk("bp_full_ready", ch_ready_o, 3'b000);
        rdy_pct = 100;
        step();
        @(negedge clk);
        chk("bp_pop_noready", ch_ready_o, 3'b000);
        rdy_pct = 0;
        step();
        @(negedge clk);
        chk("bp_level3", level_o, 3);

        // Reset mid-stream with ptr away from 0
        tick();
        rst_i = 1'b1;
        outbound_ready_i = 1'b0;
        tick();
        rst_i = 1'b0;
        ch_valid_i[1] = 1'b1; ch_data_i[1*W +: W] = $urandom;
        ch_valid_i[2] = 1'b1; ch_data_i[2*W +: W] = $urandom;
        @(negedge clk);
        chk("rst_mid_level", level_o, 0);
        chk("rst_mid_valid", outbound_valid_o, 1'b0);
        chk("rst_mid_data", outbound_data_o, 0);
        chk("rst_mid_grant", ch_ready_o, 3'b001);
        drain();

        // Randomised traffic
        en_mask = 3'b111; p_valid = 60; rdy_pct = 70;
        repeat (400) step();
        drain();
        @(negedge clk);
        chk("final_idle", idle_o, 1'b1);
        chk("final_level", level_o, 0);

`ifdef NX_EGRESS_COUNT_EN
        apply_reset(2);
        en_mask = 3'b001; p_valid = 100; rdy_pct = 100;
        seq_mode = 1'b1; seq_val = 0; seq_lim = 5;
        repeat (10) step();
        @(negedge clk);
        chk("count5", sent_count_o, 5);
        chk("count_idle", idle_o, 1'b1);
        tick();
        force dut.sent_count_q = 32'hFFFF_FFFF;
        tick();
        release dut.sent_count_q;
        seq_lim = 6;
        repeat (6) step();
        @(negedge clk);
        chk("count_wrap", sent_count_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
